data_memory_hs: RTL and testbench

- Parametrised successor to the pipeline's single-cycle word data memory.
- Word-organised RAM with byte/half/word loads and stores, sign/zero extension and a configurable wait-state count.
- Uses a req/ready/done handshake so the MEM stage can stall on multi-cycle memory.
- Sits in the MEM stage between the ALU result/rt path and the write-back mux.

---
 rtl/data_memory_hs_pkg.sv | 33 +++
 rtl/data_memory_hs_if.sv | 25 ++
 rtl/data_memory_hs_dmem_lane_align.sv | 57 +++++
 rtl/data_memory_hs.sv | 182 ++++++++++++++++++
 tb/tb_data_memory_hs.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_hs_pkg.sv
// Shared definitions for data_memory_hs: access-size codes, FSM states and
// the load extension helper used by the lane aligner.
package data_memory_hs_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        ACCESS = 2'b10
    } state_e;

    localparam int WCNT_W = 4;

    // Extend a byte (lane[7:0]) or half (lane[15:0]) to 32 bits.
    function automatic logic [31:0] extend_lane(input logic [15:0] lane,
                                                input logic        is_half,
                                                input logic        zero_ext);
        logic [31:0] r;
        if (is_half) begin
            r = zero_ext ? {16'h0000, lane} : {{16{lane[15]}}, lane};
        end else begin
            r = zero_ext ? {24'h000000, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/data_memory_hs_if.sv
// Request/response bundle between the MEM stage and data_memory_hs.
interface data_memory_hs_if #(
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              unsigned_ld;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              done;
    logic [31:0]       rdata;
    logic              err;

    modport master (
        output req, we, size, unsigned_ld, addr, wdata,
        input  ready, done, rdata, err
    );

    modport slave (
        input  req, we, size, unsigned_ld, addr, wdata,
        output ready, done, rdata, err
    );
endinterface

// File: rtl/data_memory_hs_dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for data_memory_hs.
// Produces the store byte-enable mask and replicated write data, and the
// extended load value for the selected lane. Also flags reserved sizes and
// misaligned offsets; the top decides what to do with the latter.
module dmem_lane_align
    import data_memory_hs_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        unsigned_ld,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        size_bad
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = rword[{offset, 3'b000} +: 8];
    assign half_s = rword[{offset[1], 4'b0000} +: 16];

    // Decode size into lane mask, write data placement and load extension.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = 32'h0000_0000;
        rdata_ext  = 32'h0000_0000;
        misaligned = 1'b0;
        size_bad   = 1'b0;
        case (size)
            SZ_BYTE: begin
                be         = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = extend_lane({8'h00, byte_s}, 1'b0, unsigned_ld);
            end
            SZ_HALF: begin
                be         = offset[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = extend_lane(half_s, 1'b1, unsigned_ld);
                misaligned = offset[0];
            end
            SZ_WORD: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
                misaligned = |offset;
            end
            default: begin
                size_bad = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_hs.sv
// data_memory_hs: word-organised data RAM with byte/half/word access and a
// req/ready/done handshake with WAIT_CYCLES programmable wait states.
// Optional macro DMEM_MISALIGN_TRAP_EN: when defined, misaligned half/word
// accesses fault; otherwise the low address bits are ignored for them.
module data_memory_hs
    import data_memory_hs_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    data_memory_hs_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [WCNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WCNT_W'(WAIT_CYCLES - 1) : {WCNT_W{1'b0}};
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    // Array is deliberately not reset.
    logic [31:0] mem_q [DEPTH];

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    // Effective request: live bus while idle (direct IDLE->ACCESS needs it),
    // captured copy once the access is in flight.
    logic                eff_idle_s;
    logic                eff_we_s;
    logic [1:0]          eff_size_s;
    logic                eff_uns_s;
    logic [ADDR_W-1:0]   eff_addr_s;
    logic [31:0]         eff_wdata_s;
    logic [IDX_W-1:0]    idx_s;
    logic                oor_s;
    logic                acc_err_s;
    logic [3:0]          be_s;
    logic [31:0]         wdata_lane_s;
    logic [31:0]         rdata_ext_s;
    logic                misaligned_s;
    logic                size_bad_s;

    assign eff_idle_s  = (state_q == IDLE);
    assign eff_we_s    = eff_idle_s ? bus.we          : we_q;
    assign eff_size_s  = eff_idle_s ? bus.size        : size_q;
    assign eff_uns_s   = eff_idle_s ? bus.unsigned_ld : uns_q;
    assign eff_addr_s  = eff_idle_s ? bus.addr        : addr_q;
    assign eff_wdata_s = eff_idle_s ? bus.wdata       : wdata_q;

    assign idx_s     = eff_addr_s[IDX_W+1:2];
    assign oor_s     = |(eff_addr_s >> (IDX_W + 2));
    assign acc_err_s = oor_s | size_bad_s | (TRAP_EN & misaligned_s);

    dmem_lane_align u_align (
        .size        (eff_size_s),
        .offset      (eff_addr_s[1:0]),
        .unsigned_ld (eff_uns_s),
        .wdata       (eff_wdata_s),
        .rword       (mem_q[idx_s]),
        .be          (be_s),
        .wdata_lane  (wdata_lane_s),
        .rdata_ext   (rdata_ext_s),
        .misaligned  (misaligned_s),
        .size_bad    (size_bad_s)
    );

    // Next-state, capture and registered-output computation.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    size_d  = bus.size;
                    uns_d   = bus.unsigned_ld;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end else begin
                        state_d = ACCESS;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (wcnt_q == {WCNT_W{1'b0}}) begin
                    state_d = ACCESS;
                end else begin
                    wcnt_d = wcnt_q - {{(WCNT_W-1){1'b0}}, 1'b1};
                end
            end
            ACCESS: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if ((state_d == ACCESS) && (state_q != ACCESS)) begin
            err_d   = acc_err_s;
            rdata_d = (acc_err_s || eff_we_s) ? 32'h0000_0000 : rdata_ext_s;
        end else begin
            err_d   = err_q;
            rdata_d = rdata_q;
        end
        ready_d = (state_d == IDLE);
        done_d  = (state_d == ACCESS);
    end

    // State, capture and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= {WCNT_W{1'b0}};
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= 32'h0000_0000;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Store commit on the edge leaving ACCESS; reset forces IDLE so an
    // aborted store never reaches here.
    always_ff @(posedge clk) begin
        if ((state_q == ACCESS) && we_q && !err_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_q[idx_s][8*b +: 8] <= wdata_lane_s[8*b +: 8];
                end
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_data_memory_hs.sv
// Self-checking bench for data_memory_hs: one instance with no wait states
// and one with three, a directed vector table, hand-written handshake/reset
// sequences and randomized accesses against a behavioural memory model.
module tb_data_memory_hs;

    logic clk;
    logic rst0, rst3;
    int   n_checks = 0;
    int   n_errors = 0;

    data_memory_hs_if #(.ADDR_W(32)) if0 ();
    data_memory_hs_if #(.ADDR_W(32)) if3 ();

    data_memory_hs #(.DEPTH(64), .ADDR_W(32), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk), .rst (rst0), .bus (if0)
    );
    data_memory_hs #(.DEPTH(64), .ADDR_W(32), .WAIT_CYCLES(3)) u_dut3 (
        .clk (clk), .rst (rst3), .bus (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference memory image per instance (index 0: no waits, 1: 3 waits).
    logic [31:0] refm [2][64];

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic rq, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        if (w == 0) begin
            if0.req = rq; if0.we = we; if0.size = sz; if0.unsigned_ld = uns;
            if0.addr = a; if0.wdata = wd;
        end else begin
            if3.req = rq; if3.we = we; if3.size = sz; if3.unsigned_ld = uns;
            if3.addr = a; if3.wdata = wd;
        end
    endtask

    function automatic logic get_ready(input int w);
        return (w == 0) ? if0.ready : if3.ready;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 0) ? if0.done : if3.done;
    endfunction
    function automatic logic get_err(input int w);
        return (w == 0) ? if0.err : if3.err;
    endfunction
    function automatic logic [31:0] get_rdata(input int w);
        return (w == 0) ? if0.rdata : if3.rdata;
    endfunction

    // Behavioural model: byte-addressed arithmetic over a word image.
    task automatic model(input int w, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a_in, input logic [31:0] wd,
                         output logic [31:0] rd, output logic e);
        logic [31:0] a, word, v;
        int wi, bo, hb;
        a  = a_in;
        e  = (a >= 32'd256) || (sz == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (sz == 2'd1 && (a % 2) != 0) e = 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) e = 1'b1;
`else
        if (sz == 2'd1) a = a - (a % 2);
        if (sz == 2'd2) a = a - (a % 4);
`endif
        rd = 32'h0;
        if (!e) begin
            wi   = int'(a / 4);
            bo   = int'(a % 4);
            hb   = bo / 2;
            word = refm[w][wi];
            if (we) begin
                if (sz == 2'd0)
                    word = (word & ~(32'hFF << (8*bo))) | ((wd & 32'hFF) << (8*bo));
                else if (sz == 2'd1)
                    word = (word & ~(32'hFFFF << (16*hb))) | ((wd & 32'hFFFF) << (16*hb));
                else
                    word = wd;
                refm[w][wi] = word;
            end else begin
                if (sz == 2'd0) begin
                    v = (word >> (8*bo)) & 32'hFF;
                    if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
                end else if (sz == 2'd1) begin
                    v = (word >> (16*hb)) & 32'hFFFF;
                    if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
                end else begin
                    v = word;
                end
                rd = v;
            end
        end
    endtask

    // One complete handshake; entered and left just after a falling edge.
    task automatic do_access(input int w, input string nm, input logic we, input logic [1:0] sz,
                             input logic uns, input logic [31:0] a, input logic [31:0] wd,
                             input logic chk_rd, input logic [31:0] exp_rd, input logic exp_er);
        int n, lat;
        n = 0;
        while (!get_ready(w) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!get_ready(w)) check({nm, "_ready_timeout"}, 32'(get_ready(w)), 32'd1);
        drive(w, 1'b1, we, sz, uns, a, wd);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        lat = 1;
        while (!get_done(w) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), (w == 0) ? 32'd1 : 32'd4);
        check({nm, "_err"}, 32'(get_err(w)), 32'(exp_er));
        if (chk_rd) check({nm, "_rdata"}, get_rdata(w), exp_rd);
        @(negedge clk);
        check({nm, "_done_pulse"}, 32'(get_done(w)), 32'd0);
    endtask

    vec_t vecs[21];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a, wd;
        logic        e, we, uns;
        logic [1:0]  sz;
        int          r;

        for (int i = 0; i < 64; i++) begin
            refm[0][i] = 32'h0;
            refm[1][i] = 32'h0;
        end

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h20,  32'h11223344, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h21,  32'h000000AA, 1'b0, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        1'b1, 32'h1122AA44, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h21,  32'h0,        1'b1, 32'hFFFFFFAA, 1'b0};
        vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h21,  32'h0,        1'b1, 32'h000000AA, 1'b0};
        vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h22,  32'h0,        1'b1, 32'h00001122, 1'b0};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h0,   32'h01020304, 1'b0, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, 1'b1, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h0,   32'h0,        1'b1, 32'h01020304, 1'b0};
        vecs[11] = '{1'b0, 2'd3, 1'b0, 32'h0,   32'h0,        1'b1, 32'h0,        1'b1};
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h12,  32'h0,        1'b1, 32'h0,        1'b1};
`else
        vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h12,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
`endif
        vecs[13] = '{1'b1, 2'd1, 1'b0, 32'h26,  32'hFFFFBEEF, 1'b0, 32'h0,        1'b0};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h24,  32'h0,        1'b1, 32'hBEEF0000, 1'b0};
        vecs[15] = '{1'b0, 2'd1, 1'b0, 32'h26,  32'h0,        1'b1, 32'hFFFFBEEF, 1'b0};
        vecs[16] = '{1'b0, 2'd1, 1'b1, 32'h26,  32'h0,        1'b1, 32'h0000BEEF, 1'b0};
        vecs[17] = '{1'b0, 2'd0, 1'b0, 32'h1,   32'h0,        1'b1, 32'h00000003, 1'b0};
        vecs[18] = '{1'b1, 2'd0, 1'b0, 32'h27,  32'h12345680, 1'b0, 32'h0,        1'b0};
        vecs[19] = '{1'b0, 2'd0, 1'b0, 32'h27,  32'h0,        1'b1, 32'hFFFFFF80, 1'b0};
        vecs[20] = '{1'b0, 2'd2, 1'b0, 32'h24,  32'h0,        1'b1, 32'h80EF0000, 1'b0};

        // Reset state.
        rst0 = 1'b1;
        rst3 = 1'b1;
        drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            check("rst_ready", 32'(get_ready(w)), 32'd1);
            check("rst_done",  32'(get_done(w)),  32'd0);
            check("rst_rdata", get_rdata(w),      32'h0);
            check("rst_err",   32'(get_err(w)),   32'd0);
        end
        rst0 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);

        // Directed vector table on the zero-wait instance.
        for (int i = 0; i < 21; i++) begin
            model(0, vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, rd, e);
            do_access(0, $sformatf("vec%0d", i), vecs[i].we, vecs[i].sz, vecs[i].uns,
                      vecs[i].addr, vecs[i].wd, vecs[i].chk_rd, vecs[i].rd, vecs[i].er);
        end

        // Wait-state timing with req held high throughout.
        do_access(1, "w3_seed", 1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
        model(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFEF00D, rd, e);
        drive(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("w3_ready_t%0d", k), 32'(if3.ready), 32'd0);
            check($sformatf("w3_done_t%0d", k),  32'(if3.done),  (k == 4) ? 32'd1 : 32'd0);
        end
        check("w3_rdata", if3.rdata, 32'hCAFEF00D);
        @(negedge clk);
        check("w3_ready_t5", 32'(if3.ready), 32'd1);
        check("w3_done_t5",  32'(if3.done),  32'd0);
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Reset during WAIT of a store aborts it.
        do_access(1, "abort_seed", 1'b1, 2'd2, 1'b0, 32'h8, 32'h0BADF00D, 1'b0, 32'h0, 1'b0);
        model(1, 1'b1, 2'd2, 1'b0, 32'h8, 32'h0BADF00D, rd, e);
        drive(1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h8, 32'h5555AAAA);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        check("abort_in_wait", 32'(if3.ready), 32'd0);
        rst3 = 1'b1;
        #1;
        check("abort_ready", 32'(if3.ready), 32'd1);
        check("abort_done",  32'(if3.done),  32'd0);
        @(negedge clk);
        rst3 = 1'b0;
        @(negedge clk);
        do_access(1, "abort_reload", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b1, 32'h0BADF00D, 1'b0);

        // Randomized accesses against the model on both instances.
        for (int i = 0; i < 200; i++) begin
            int w;
            w   = i % 2;
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 9));
            sz  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 15) == 0)
                a = 32'h100 + 32'($urandom_range(0, 4095));
            else
                a = 32'($urandom_range(0, 63));
            wd = $urandom;
            model(w, we, sz, uns, a, wd, rd, e);
            do_access(w, $sformatf("rnd%0d", i), we, sz, uns, a, wd, (!we) || e, rd, e);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
